// File: rtl/neuron_mac.sv
// neuron_mac: streaming signed MAC with bias, scaled/saturated into a sigmoid ROM address, result on valid/ready
module neuron_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int FRAC_SHIFT   = 4,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  input  logic signed [WEIGHT_WIDTH-1:0] in_weight,
  input  logic                           in_last,
  input  logic signed [ACC_WIDTH-1:0]    bias,
  output logic [ADDR_WIDTH-1:0]          sig_addr,
  input  logic [7:0]                     sig_q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_data,
  output logic                           busy
);
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-ADDR_WIDTH+1){1'b0}}, {(ADDR_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {ACC, ADDR, ROM_WAIT, CAPTURE, OUT} state_t;
  state_t state, state_nx;
  logic first, beat;
  logic signed [PW-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc, prod_ext, acc_sum, shifted;
  logic [ADDR_WIDTH-1:0] sat;
  assign prod     = in_data * in_weight;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign acc_sum  = (first ? bias : acc) + prod_ext;
  assign shifted  = acc >>> FRAC_SHIFT;
  assign sat      = shifted > SMAX ? SMAX[ADDR_WIDTH-1:0] :
                    shifted < SMIN ? SMIN[ADDR_WIDTH-1:0] : shifted[ADDR_WIDTH-1:0];
  assign in_ready = state == ACC;
  assign beat     = in_valid && in_ready;
  assign busy     = state != ACC || !first;
  always_comb begin
    state_nx = state;
    case (state)
      ACC:      state_nx = beat && in_last ? ADDR : ACC;
      ADDR:     state_nx = ROM_WAIT;
      ROM_WAIT: state_nx = CAPTURE;
      CAPTURE:  state_nx = OUT;
      OUT:      state_nx = out_ready ? ACC : OUT;
      default:  state_nx = ACC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else state <= state_nx;
  end
  // Offset-binary address: adding 2^(ADDR_WIDTH-1) is just an MSB flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      sig_addr  <= {1'b1, {(ADDR_WIDTH-1){1'b0}}};
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (beat) begin
        acc   <= acc_sum;
        first <= 1'b0;
      end
      if (state == ADDR) sig_addr <= {~sat[ADDR_WIDTH-1], sat[ADDR_WIDTH-2:0]};
      if (state == CAPTURE) begin
        out_data  <= sig_q;
        out_valid <= 1'b1;
      end
      if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
        first     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac with a registered sigmoid ROM stand-in
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic signed [7:0] in_data, in_weight;
  logic signed [23:0] bias;
  logic [13:0] sig_addr, mon_a;
  logic [7:0] sig_q, out_data;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0, first_cyc = 0;
  logic [13:0] exp_q[$];

  neuron_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .sig_addr(sig_addr), .sig_q(sig_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [13:0] a);
    return (a[7:0] ^ {2'b00, a[13:8]}) + 8'h53;
  endfunction
  always @(posedge clk) sig_q <= rom(sig_addr);

  // Reference: wrap the exact sum to 24 bits, floor-divide by 16, clamp, offset by 8192
  function automatic logic [13:0] model_addr(input longint t);
    logic signed [23:0] w;
    longint s;
    w = t[23:0];
    s = w;
    s = s >>> 4;
    if (s > 8191) s = 8191;
    if (s < -8192) s = -8192;
    return 14'(s + 8192);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got %0h expected none", out_data);
      end else begin
        mon_a = exp_q.pop_front();
        check("mon_sig_addr", 32'(sig_addr), 32'(mon_a));
        check("mon_out_data", 32'(out_data), 32'(rom(mon_a)));
      end
    end
  end

  task automatic beat(input int d, input int w, input logic l, input logic [23:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 expected 1");
    end
    in_valid = 1'b1; in_data = 8'(d); in_weight = 8'(w); in_last = l; bias = b;
    @(posedge clk); #1;
    last_cyc = cyc;
    in_valid = 1'b0; in_data = 8'($urandom); in_weight = 8'($urandom);
    in_last = 1'($urandom); bias = 24'($urandom);
  endtask

  task automatic vec(input logic signed [23:0] b, input int d[$], input int w[$]);
    longint t = b;
    for (int i = 0; i < d.size(); i++) begin
      t += d[i] * w[i];
      beat(d[i], w[i], i == d.size() - 1, i == 0 ? b : 24'($urandom));
      if (i == 0) first_cyc = last_cyc;
    end
    exp_q.push_back(model_addr(t));
  endtask

  task automatic directed(input string name, input logic signed [23:0] b, input int d[$],
                          input int w[$], input logic [13:0] ea, input logic [7:0] ed);
    out_ready = 1'b0;
    vec(b, d, w);
    @(posedge clk); #1;
    check({name, "_addr"}, 32'(sig_addr), 32'(ea));
    check({name, "_e1_valid"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    check({name, "_e2_valid"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    check({name, "_e3_valid"}, 32'(out_valid), 1);
    check({name, "_e3_data"}, 32'(out_data), 32'(ed));
    repeat (6) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(out_valid), 1);
      check({name, "_hold_data"}, 32'(out_data), 32'(ed));
      check({name, "_hold_in_ready"}, 32'(in_ready), 0);
      check({name, "_hold_busy"}, 32'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_clr_valid"}, 32'(out_valid), 0);
    check({name, "_in_ready"}, 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int dq[$], wq[$];
    int prev_first, prev_n, n, k;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0; in_last = 1'b0;
    bias = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sig_addr", 32'(sig_addr), 32'h2000);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);

    dq = '{16}; wq = '{16};
    directed("single", 24'sd0, dq, wq, 14'h2010, 8'h83);
    dq = '{3, -2, 10, 1}; wq = '{5, 7, -1, 1};
    directed("four", -24'sd32, dq, wq, 14'h1FFD, rom(14'h1FFD));
    dq = '{0}; wq = '{0};
    directed("sat_hi", 24'sd200000, dq, wq, 14'h3FFF, rom(14'h3FFF));
    directed("sat_lo", -24'sd200000, dq, wq, 14'h0000, rom(14'h0000));
    directed("floor", -24'sd1, dq, wq, 14'h1FFF, rom(14'h1FFF));

    out_ready = 1'b1;
    prev_first = 0; prev_n = 0;
    for (int v = 0; v < 4; v++) begin
      n = v + 1;
      dq.delete(); wq.delete();
      for (int i = 0; i < n; i++) begin
        dq.push_back($urandom_range(0, 255) - 128);
        wq.push_back($urandom_range(0, 255) - 128);
      end
      vec(24'($urandom_range(0, 20000)) - 24'sd10000, dq, wq);
      if (v > 0) check("period", 32'(first_cyc - prev_first), 32'(prev_n + 4));
      prev_first = first_cyc; prev_n = n;
    end

    beat(5, 5, 1'b0, 24'sd4000);
    beat(7, 9, 1'b0, 24'sd0);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(sig_addr), 32'h2000);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dq = '{2}; wq = '{3};
    vec(24'sd100, dq, wq);
    @(posedge clk); #1;
    check("post_rst_addr", 32'(sig_addr), 32'h2006);

    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(1, 6);
      dq.delete(); wq.delete();
      for (int i = 0; i < n; i++) begin
        dq.push_back($urandom_range(0, 255) - 128);
        wq.push_back($urandom_range(0, 255) - 128);
      end
      vec(24'($urandom_range(0, 600000)) - 24'sd300000, dq, wq);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate front end for the sigmoid activation ROM. It accepts a stream of signed input/weight pairs with a valid/ready handshake and adds their products to a bias. On the last pair it scales and saturates the sum into a 14-bit offset-binary ROM address. It then drives the sigmoid ROM, captures the 8-bit activation and presents it on a valid/ready output port.

## Interface
- DATA_WIDTH, 8: width of signed input activation `in_data`.
- WEIGHT_WIDTH, 8: width of signed weight `in_weight`.
- ACC_WIDTH, 24: width of the signed accumulator and the bias.
- FRAC_SHIFT, 4: arithmetic right shift applied to the accumulator before saturation.
- ADDR_WIDTH, 14: sigmoid ROM address width.
- Ports, in order `name direction width: meaning`:
  - clk  in  1: single clock; all logic is rising-edge.
  - rst_n  in  1: reset, asynchronous and active-low.
  - in_valid  in  1: input pair valid.
  - in_ready  out  1: block can accept a pair.
  - in_data  in  DATA_WIDTH: signed activation.
  - in_weight  in  WEIGHT_WIDTH: signed weight.
  - in_last  in  1: marks the final pair of a vector.
  - bias  in  ACC_WIDTH: signed bias, sampled on the first beat of each vector.
  - sig_addr  out  ADDR_WIDTH: address to the sigmoid ROM.
  - sig_q  in  8: ROM data; registered, one-cycle read latency.
  - out_valid  out  1: activation result valid.
  - out_ready  in  1: consumer accepts the result.
  - out_data  out  8: activation result.
  - busy  out  1: high in any state other than ACC, and in ACC once a vector is in progress.

## Operation
- States: ACC, ADDR, ROM_WAIT, CAPTURE, OUT. The block resets into ACC with the first-beat flag set.
- **ACC**
  - `in_ready`=1. A beat is a cycle with `in_valid && in_ready`.
  - First beat of a vector: acc <= sext(bias) + sext(in_data*in_weight).
  - Later beats: acc <= acc + sext(product).
  - Products are full-width signed (DATA_WIDTH+WEIGHT_WIDTH bits). Accumulator additions wrap modulo 2^ACC_WIDTH; no overflow detection.
  - A beat with `in_last`=1 goes to ADDR. A single-beat vector (first and last together) is legal.
- **ADDR**
  - `in_ready`=0.
  - s = acc >>> FRAC_SHIFT (arithmetic shift, i.e. floor).
  - Saturate s to [-2^(ADDR_WIDTH-1), 2^(ADDR_WIDTH-1)-1], i.e. [-8192, 8191].
  - sig_addr <= sat + 8192, which equals sat with its MSB inverted.
  - Go to ROM_WAIT.
- **ROM_WAIT**: hold `sig_addr`. The ROM registers it on this edge. Go to CAPTURE.
- **CAPTURE**: out_data <= sig_q; out_valid <= 1. Go to OUT.
- **OUT**
  - Hold `out_valid` and `out_data` stable until `out_ready`=1.
  - On acceptance: out_valid <= 0, set the first-beat flag, return to ACC.
  - `in_ready` stays 0 throughout OUT, so there is no overlap between vectors.
- **Async reset** (any state, including mid-vector or mid-output):
  - state=ACC, acc=0, first-beat flag set.
  - sig_addr=14'h2000 (sigmoid zero point).
  - out_data=0, out_valid=0.
  - in_ready=1 once rst_n deasserts; busy=0.
  - A partially accumulated vector is discarded.
- `in_data`, `in_weight`, `in_last` and `bias` are ignored when no beat occurs.

## Timing
- `in_ready` is combinational from state only, not from `in_valid`. One beat per cycle is sustained in ACC.
- Let the last beat be accepted at edge E0:
  - E1: `sig_addr` updated.
  - E2: ROM output registered.
  - E3: `out_valid` rises and `out_data` is valid.
  - Latency from last beat to result is therefore 3 cycles.
- Earliest next beat: the cycle after the edge at which `out_valid && out_ready` is sampled high.
- If `out_ready` is already high at E3, the result is consumed on E4 and `in_ready` is high from E4. Minimum vector period is N+4 cycles.
- `sig_addr` changes only on the ADDR-to-ROM_WAIT edge and on reset.

## Test plan
- Single-beat vector with bias=0, data=16, weight=16 -> acc=256, s=16, sig_addr=0x2010. With the ROM model returning 0x83, out_data=0x83 and `out_valid` rises 3 cycles after the beat.
- 4-beat vector with bias=-32 and pairs (3,5),(-2,7),(10,-1),(1,1) -> acc=-32+15-14-10+1=-40, s=-3, sig_addr=0x1FFD.
- Saturation:
  - bias=200000, pair (0,0) -> sig_addr=0x3FFF.
  - bias=-200000 -> sig_addr=0x0000.
  - bias=-1 -> s=-1 (floor), sig_addr=0x1FFF.
- Backpressure: hold `out_ready`=0 for 6 cycles after `out_valid` -> `out_data` and `out_valid` stay stable and `in_ready` stays 0. Raising `out_ready` clears `out_valid` on the next edge and `in_ready`=1 in the following cycle.
- Throughput: back-to-back vectors with `in_valid` and `out_ready` held high -> each vector takes exactly N+4 cycles, and the bias is resampled per vector.
- Reset mid-operation:
  - Assert rst_n=0 after 2 of 4 beats -> outputs immediately return to reset values (sig_addr=0x2000, out_valid=0).
  - A fresh single-beat vector after release produces a result based only on the new bias and product.
